gray_to_binary_arbiter: RTL
===========================

# gray_to_binary_arbiter

Shares one Gray-to-binary conversion datapath among several requesters. Each requester presents a Gray code with a valid/ready handshake. A round-robin scheduler grants one request at a time, registers the conversion, and returns the binary result tagged with the requester ID over a valid/ready response channel. It sits between multiple Gray-code producers (for example, encoder or counter readouts) and one downstream consumer.

## Interface
- NUM_REQ, default 4: number of requesters; ≥2.
- WIDTH, default 4: code width in bits; ≥2.
- ID_W, default $clog2(NUM_REQ): requester ID width (derived, not overridden).
- Clk  input  1  single clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Req_Valid  input  NUM_REQ  per-requester request valid.
- Req_Gray  input  NUM_REQ*WIDTH  packed Gray codes; requester i occupies bits [i*WIDTH +: WIDTH].
- Req_Ready  output  NUM_REQ  one-hot accept strobe; at most one bit high per cycle.
- Rsp_Valid  output  1  response valid.
- Rsp_Binary  output  WIDTH  converted binary value.
- Rsp_Id  output  ID_W  index of the requester that owns this response.
- Rsp_Ready  input  1  consumer accepts the response.

## Operation
- FSM states: IDLE, CONVERT, RESPOND.
- IDLE:
  - If any Req_Valid bit is high, grant the first set bit searching upward from Prio_Ptr with wrap-around.
  - Req_Ready[grant] is high combinationally during this cycle, so a transfer occurs in this cycle.
  - Latch the granted Gray code into Gray_Reg and the index into Id_Reg; go to CONVERT.
  - If no Req_Valid bit is high, stay in IDLE with Req_Ready all zeros.
- CONVERT:
  - Gray_Reg drives the shared converter: b[WIDTH-1] = g[WIDTH-1]; b[k] = b[k+1] ^ g[k].
  - Register the result into Rsp_Binary; go to RESPOND.
- RESPOND:
  - Rsp_Valid is high. Rsp_Binary and Rsp_Id are held stable until the handshake completes.
  - When Rsp_Valid && Rsp_Ready: Prio_Ptr ← (Id_Reg + 1) mod NUM_REQ, then go to IDLE.
- Req_Ready is low in CONVERT and RESPOND. No new request is accepted while one is in flight.
- Requesters hold Req_Valid and Req_Gray until they see Req_Ready. A change in Req_Gray before acceptance is not an error; the value present in the accept cycle is used.
- Prio_Ptr wrap: an ID of NUM_REQ-1 moves the pointer to 0. The modulo is explicit when NUM_REQ is not a power of two.
- Simultaneous requests: exactly one is granted. Every continuously-valid requester is served within NUM_REQ transactions (no starvation).
- Reset value of every output and register: Req_Ready=0, Rsp_Valid=0, Rsp_Binary=0, Rsp_Id=0, Prio_Ptr=0, Gray_Reg=0, Id_Reg=0, state=IDLE.
- Reset asserted mid-transaction: the in-flight transaction is dropped with no response, and all state returns to the reset values immediately (asynchronous).

## Timing
- Request accepted at edge N (Req_Valid && Req_Ready in cycle N-1→N).
- State is CONVERT in cycle N and RESPOND in cycle N+1; Rsp_Valid is high in cycle N+1 (2-cycle latency from the accept cycle).
- With Rsp_Ready held high, the response completes at edge N+2. The next accept occurs at the earliest in IDLE during cycle N+2, giving peak throughput of one conversion per 3 cycles.
- Rsp_Ready low stalls in RESPOND indefinitely, with outputs held.
- Req_Ready depends combinationally on Req_Valid and state only, never on Rsp_Ready.

## Structure
- Shared package gray_arb_pkg: state enum typedef (IDLE, CONVERT, RESPOND) and the default NUM_REQ/WIDTH constants.
- One sub-module, gray_to_binary_core: parameterised WIDTH, purely combinational, instantiated once on Gray_Reg.
- The round-robin grant stays inline as a wrapped priority search; no separate module.

## Test plan
- Single request, NUM_REQ=4, WIDTH=4: Req_Valid=0001, Req_Gray[0]=4'b0110 → Req_Ready=0001 for one cycle; 2 cycles later Rsp_Valid=1, Rsp_Binary=4'b0100, Rsp_Id=0.
- All four requesters valid, Gray 1111/1000/0001/0110 for IDs 0..3, Rsp_Ready=1 → responses in ID order 0,1,2,3 with Binary 1010/1111/0001/0100, spaced 3 cycles apart.
- Fairness and wrap: after serving ID 3, requesters 0 and 3 both valid → ID 0 granted first (Prio_Ptr=0), then ID 3.
- Backpressure: Rsp_Ready=0 for 5 cycles in RESPOND → Rsp_Valid, Rsp_Binary and Rsp_Id are stable and Req_Ready stays 0000; Rsp_Ready=1 completes the response and the next accept follows in the following cycle.
- Reset mid-operation: drop Reset_n during CONVERT → all outputs go to 0 immediately, no response is produced, and after release Prio_Ptr=0 so requester 0 has priority.
- Exhaustive: the bench compares all 16 Gray codes on requester 2 against a software model and checks Rsp_Id=2 on each.

Source files
------------

// File: rtl/gray_arb_pkg.sv
// Shared types and default sizing for the Gray-to-binary arbiter slice.
package gray_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    RESPOND = 2'd2
  } arb_state_e;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_WIDTH   = 4;

endpackage : gray_arb_pkg

// File: rtl/gray_to_binary_core.sv
// Purely combinational Gray-to-binary converter shared by all requesters.
module gray_to_binary_core
  import gray_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] binary_o
);

  // Binary bit k is the XOR of all Gray bits at or above k, which is the
  // closed form of the MSB-first chain b[k] = b[k+1] ^ g[k].
  always_comb begin
    binary_o = '0;
    for (int k = 0; k < WIDTH; k++) begin
      binary_o[k] = ^(gray_i >> k);
    end
  end

endmodule : gray_to_binary_core

// File: rtl/gray_to_binary_arbiter.sv
// Round-robin arbiter sharing one registered Gray-to-binary conversion among
// NUM_REQ valid/ready requesters; results return tagged with the requester ID.
module gray_to_binary_arbiter
  import gray_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEFAULT_NUM_REQ,
  parameter  int WIDTH   = DEFAULT_WIDTH,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [NUM_REQ-1:0]       Req_Valid,
  input  logic [NUM_REQ*WIDTH-1:0] Req_Gray,
  output logic [NUM_REQ-1:0]       Req_Ready,
  output logic                     Rsp_Valid,
  output logic [WIDTH-1:0]         Rsp_Binary,
  output logic [ID_W-1:0]          Rsp_Id,
  input  logic                     Rsp_Ready
);

  arb_state_e       state_q, state_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] rsp_binary_q, rsp_binary_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  prio_ptr_q, prio_ptr_d;
  logic [WIDTH-1:0] core_binary;

  logic             grant_found;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W:0]    rr_idx;

  // Wrapped priority search starting at prio_ptr_q; the extra index bit keeps
  // ptr + k from overflowing before the explicit modulo for non-power-of-two NUM_REQ.
  always_comb begin : rr_search
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_id    = '0;
    rr_idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = {1'b0, prio_ptr_q} + (ID_W+1)'(k);
      if (rr_idx >= (ID_W+1)'(NUM_REQ)) begin
        rr_idx = rr_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && Req_Valid[rr_idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = rr_idx[ID_W-1:0];
      end
    end
  end

  // Accept strobe depends only on state and Req_Valid, never on Rsp_Ready.
  always_comb begin : ready_decode
    Req_Ready = '0;
    if (state_q == IDLE && grant_found) begin
      Req_Ready[grant_id] = 1'b1;
    end
  end

  gray_to_binary_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .gray_i   (gray_q),
    .binary_o (core_binary)
  );

  always_comb begin : fsm_next
    state_d      = state_q;
    gray_d       = gray_q;
    id_d         = id_q;
    rsp_binary_d = rsp_binary_q;
    prio_ptr_d   = prio_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          gray_d  = Req_Gray[grant_id*WIDTH +: WIDTH];
          id_d    = grant_id;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        rsp_binary_d = core_binary;
        state_d      = RESPOND;
      end
      RESPOND: begin
        if (Rsp_Ready) begin
          prio_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      gray_q       <= '0;
      id_q         <= '0;
      rsp_binary_q <= '0;
      prio_ptr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q      <= state_d;
      gray_q       <= gray_d;
      id_q         <= id_d;
      rsp_binary_q <= rsp_binary_d;
      prio_ptr_q   <= prio_ptr_d;
    end
  end

  assign Rsp_Valid  = (state_q == RESPOND);
  assign Rsp_Binary = rsp_binary_q;
  assign Rsp_Id     = id_q;

  a_ready_onehot0 : assert property (@(posedge Clk) disable iff (!Reset_n)
    $onehot0(Req_Ready));

endmodule : gray_to_binary_arbiter
